multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle FSM that sequences the 8-bit register-file/ALU datapath.
- Fetches 32-bit RV32I-subset instructions over a req/ack instruction port, decodes them and drives the datapath control fields.
- Handles PC update, branches, jumps with link, and load/store handshakes.
- Sits between instruction memory, the datapath and the data-memory request/ack port.

Parameters:
NBITS, 8, datapath/PC width
NREGS, 32, register count; register index width is $clog2(NREGS)
WIDTH_ALUF, 4, ALUControl width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
imem_addr  out  NBITS  PC (byte address)
imem_req  out  1  instruction fetch request
imem_ack  in  1  imem_rdata valid this cycle
imem_rdata  in  32  instruction word
RS1  out  $clog2(NREGS)  source register 1 index
RS2  out  $clog2(NREGS)  source register 2 index
RD  out  $clog2(NREGS)  destination register index
IMM  out  NBITS  signed immediate, truncated to NBITS
ALUControl  out  WIDTH_ALUF  ALU operation
ALUSrc  out  1  1 = ALU B operand is IMM
MemtoReg  out  1  write-back selects ReadData
RegWrite  out  1  register-file write enable (one cycle)
link  out  1  write-back selects pclink
pclink  out  NBITS  PC+4 for jal/jalr
PCReg  in  NBITS  RS1 value from datapath
Zero, Neg, Carry  in  1 each  ALU flags
dmem_read  out  1  load request
dmem_write  out  1  store request
dmem_ack  in  1  data-memory access complete
illegal  out  1  sticky unsupported-opcode flag
state_dbg  out  3  current FSM state

Behaviour:
- Reset state:
  - State FETCH, PC=0, instruction register=0, illegal=0.
  - All strobes (imem_req, RegWrite, dmem_read, dmem_write, link) = 0.
  - ALUControl=ALU_ADD; RS1/RS2/RD/IMM = 0.
- Reset is synchronous and wins over any state, including mid-handshake; an outstanding req is dropped with no write-back.
- Outputs are registered from state and instruction register; no combinational path from imem_rdata to control outputs.
- FETCH:
  - imem_req=1 and imem_addr=PC held stable until imem_ack.
  - On ack: latch imem_rdata into the instruction register and go to DECODE.
  - Unbounded wait; req stays high.
- DECODE (1 cycle):
  - Drive RS1/RS2/RD from instr[19:15]/[24:20]/[11:7].
  - IMM per format (I, S, B, J), sign-extended then truncated to NBITS.
  - Unsupported opcode/funct: set illegal, PC unchanged, go to HALT.
- EXEC (1 cycle):
  - R-type add/sub/and/or/xor: ALUSrc=0.
  - addi/lw/sw: ALUSrc=1, ALU_ADD.
  - beq/bne/blt: ALUSrc=0, ALU_SUB. Taken when beq&Zero, bne&!Zero, blt&Neg; then PC=PC+IMM, else PC=PC+4 (mod 2^NBITS).
  - Branches return to FETCH after EXEC.
- MEM:
  - lw: dmem_read=1; sw: dmem_write=1. Held until dmem_ack.
  - sw: PC+=4 and go to FETCH on ack.
  - lw: go to WB on ack.
- WB (1 cycle), RegWrite=1:
  - lw: MemtoReg=1.
  - jal: link=1, pclink=PC+4, PC=PC+IMM.
  - jalr: link=1, pclink=PC+4, PC=(PCReg+IMM)&~1.
  - ALU ops: PC+=4.
  - Then FETCH.
- RegWrite with RD=0 is allowed (datapath forces x0=0).
- HALT: absorbing state; only reset exits; all strobes 0.
- PC arithmetic wraps at 2^NBITS; no misalignment trap.
- Cycles per instruction, with memory acks in the same cycle as req: ALU 4, branch 3, lw 5, sw 4, jal/jalr 4.

Decomposition:
- Package ctrl_pkg holds:
  - State enum: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - ALU op enum: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4.
  - Opcode constants: OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BR=1100011, OP_JAL=1101111, OP_JALR=1100111.
- One sub-module, instr_decoder: combinational fields, IMM and instruction class from the instruction register.

Test Plan:
- Reset, then hold imem_ack low 5 cycles -> imem_req=1, imem_addr=0 stable, state_dbg=FETCH, no RegWrite.
- Fetch addi x1,x0,5 with ack after 2 cycles -> DECODE, EXEC(ALUSrc=1, IMM=5, ALU_ADD), WB with RegWrite=1 RD=1 for exactly 1 cycle; next imem_addr=4.
- beq x0,x0,-8 at PC=12, Zero=1 -> next imem_addr=4; same with Zero=0 -> imem_addr=16; RegWrite never asserted.
- lw x2,4(x1) with dmem_ack delayed 3 cycles -> dmem_read held 3 cycles, WB MemtoReg=1 RD=2; sw -> dmem_write, no RegWrite, PC+4.
- jal x1,+16 at PC=8 -> link=1, pclink=12, RD=1, next imem_addr=24; jalr x0,0(x1) with PCReg=13 -> imem_addr=12.
- Opcode 0000000 -> illegal=1, state HALT, imem_req=0 indefinitely; reset asserted mid-MEM with dmem_read high -> next cycle FETCH, PC=0, dmem_read=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_pkg                                                                   |
// | Shared types and opcode constants for the multicycle controller.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4
  } alu_op_t;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JAL     = 3'd4,
    CL_JALR    = 3'd5,
    CL_ILLEGAL = 3'd6
  } iclass_t;

  typedef enum logic [1:0] {
    BR_EQ = 2'd0,
    BR_NE = 2'd1,
    BR_LT = 2'd2
  } br_kind_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  function automatic logic branch_taken(input br_kind_t kind, input logic zero, input logic neg);
    case (kind)
      BR_EQ:   return zero;
      BR_NE:   return !zero;
      BR_LT:   return neg;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_decoder                                                              |
// | Combinational field, immediate and class decode of the instruction reg.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int RW    = 5
) (
  input  logic [31:0]      i_instr,
  output logic [RW-1:0]    o_rs1,
  output logic [RW-1:0]    o_rs2,
  output logic [RW-1:0]    o_rd,
  output logic [NBITS-1:0] o_imm,
  output alu_op_t          o_alu_op,
  output logic             o_alu_src,
  output iclass_t          o_class,
  output br_kind_t         o_br_kind
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm32;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  assign o_rs1 = RW'(i_instr[19:15]);
  assign o_rs2 = RW'(i_instr[24:20]);
  assign o_rd  = RW'(i_instr[11:7]);
  assign o_imm = NBITS'(w_imm32);

  always_comb begin
    o_class   = CL_ILLEGAL;
    o_alu_op  = ALU_ADD;
    o_alu_src = 1'b0;
    o_br_kind = BR_EQ;
    w_imm32   = '0;
    case (w_opcode)
      OP_R: begin
        o_class = CL_ALU;
        case ({w_funct7, w_funct3})
          {7'h00, 3'b000}: o_alu_op = ALU_ADD;
          {7'h20, 3'b000}: o_alu_op = ALU_SUB;
          {7'h00, 3'b111}: o_alu_op = ALU_AND;
          {7'h00, 3'b110}: o_alu_op = ALU_OR;
          {7'h00, 3'b100}: o_alu_op = ALU_XOR;
          default:         o_class  = CL_ILLEGAL;
        endcase
      end
      OP_I: begin
        w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
        o_alu_src = 1'b1;
        if (w_funct3 == 3'b000) o_class = CL_ALU;
      end
      OP_LOAD: begin
        w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
        o_alu_src = 1'b1;
        if (w_funct3 == 3'b010) o_class = CL_LOAD;
      end
      OP_STORE: begin
        w_imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        o_alu_src = 1'b1;
        if (w_funct3 == 3'b010) o_class = CL_STORE;
      end
      OP_BR: begin
        w_imm32  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
        o_alu_op = ALU_SUB;
        case (w_funct3)
          3'b000:  begin o_class = CL_BRANCH; o_br_kind = BR_EQ; end
          3'b001:  begin o_class = CL_BRANCH; o_br_kind = BR_NE; end
          3'b100:  begin o_class = CL_BRANCH; o_br_kind = BR_LT; end
          default: o_class = CL_ILLEGAL;
        endcase
      end
      OP_JAL: begin
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                   i_instr[30:21], 1'b0};
        o_class = CL_JAL;
      end
      OP_JALR: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        if (w_funct3 == 3'b000) o_class = CL_JALR;
      end
      default: o_class = CL_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_controller                                                      |
// | Fetch/decode/exec/mem/wb sequencer for the 8-bit RV32I-subset datapath.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [NBITS-1:0]         imem_addr,
  output logic                     imem_req,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic [$clog2(NREGS)-1:0] RS1,
  output logic [$clog2(NREGS)-1:0] RS2,
  output logic [$clog2(NREGS)-1:0] RD,
  output logic [NBITS-1:0]         IMM,
  output logic [WIDTH_ALUF-1:0]    ALUControl,
  output logic                     ALUSrc,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     link,
  output logic [NBITS-1:0]         pclink,
  input  logic [NBITS-1:0]         PCReg,
  input  logic                     Zero,
  input  logic                     Neg,
  input  logic                     Carry,
  output logic                     dmem_read,
  output logic                     dmem_write,
  input  logic                     dmem_ack,
  output logic                     illegal,
  output logic [2:0]               state_dbg
);

  localparam int                RW         = $clog2(NREGS);
  localparam logic [NBITS-1:0]  c_PC_STEP  = NBITS'(4);
  localparam logic [NBITS-1:0]  c_LSB_MASK = ~NBITS'(1);

  state_t            r_state, w_state_nxt;
  logic [NBITS-1:0]  r_pc, w_pc_nxt;
  logic [31:0]       r_ir, w_ir_nxt;
  logic              r_illegal, w_illegal_nxt;
  logic              r_imem_req, w_imem_req_nxt;
  logic              r_dmem_read, w_dmem_read_nxt;
  logic              r_dmem_write, w_dmem_write_nxt;
  logic              r_regwrite, w_regwrite_nxt;
  logic              r_memtoreg, w_memtoreg_nxt;
  logic              r_link, w_link_nxt;

  logic [RW-1:0]     w_rs1, w_rs2, w_rd;
  logic [NBITS-1:0]  w_imm;
  alu_op_t           w_alu_op;
  logic              w_alu_src;
  iclass_t           w_class;
  br_kind_t          w_br_kind;
  logic [NBITS-1:0]  w_pc_plus4, w_pc_plus_imm, w_jalr_target;
  logic              w_unused_carry;

  instr_decoder #(
    .NBITS (NBITS),
    .RW    (RW)
  ) u_dec (
    .i_instr   (r_ir),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_rd      (w_rd),
    .o_imm     (w_imm),
    .o_alu_op  (w_alu_op),
    .o_alu_src (w_alu_src),
    .o_class   (w_class),
    .o_br_kind (w_br_kind)
  );

  assign w_pc_plus4     = r_pc + c_PC_STEP;
  assign w_pc_plus_imm  = r_pc + w_imm;
  assign w_jalr_target  = (PCReg + w_imm) & c_LSB_MASK;
  assign w_unused_carry = Carry;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_illegal_nxt = r_illegal;
    case (r_state)
      FETCH: begin
        // ack only counts once the request is actually on the port
        if (r_imem_req && imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (w_class == CL_ILLEGAL) begin
          w_illegal_nxt = 1'b1;
          w_state_nxt   = HALT;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        case (w_class)
          CL_BRANCH: begin
            w_pc_nxt    = branch_taken(w_br_kind, Zero, Neg) ? w_pc_plus_imm : w_pc_plus4;
            w_state_nxt = FETCH;
          end
          CL_LOAD, CL_STORE: w_state_nxt = MEM;
          default:           w_state_nxt = WB;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          if (w_class == CL_STORE) begin
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = WB;
          end
        end
      end
      WB: begin
        case (w_class)
          CL_JAL:  w_pc_nxt = w_pc_plus_imm;
          CL_JALR: w_pc_nxt = w_jalr_target;
          default: w_pc_nxt = w_pc_plus4;
        endcase
        w_state_nxt = FETCH;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase

    // strobes are registered against the state being entered
    w_imem_req_nxt   = (w_state_nxt == FETCH);
    w_dmem_read_nxt  = (w_state_nxt == MEM) && (w_class == CL_LOAD);
    w_dmem_write_nxt = (w_state_nxt == MEM) && (w_class == CL_STORE);
    w_regwrite_nxt   = (w_state_nxt == WB);
    w_memtoreg_nxt   = (w_state_nxt == WB) && (w_class == CL_LOAD);
    w_link_nxt       = (w_state_nxt == WB) && ((w_class == CL_JAL) || (w_class == CL_JALR));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= '0;
      r_ir         <= '0;
      r_illegal    <= 1'b0;
      r_imem_req   <= 1'b0;
      r_dmem_read  <= 1'b0;
      r_dmem_write <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_link       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ir         <= w_ir_nxt;
      r_illegal    <= w_illegal_nxt;
      r_imem_req   <= w_imem_req_nxt;
      r_dmem_read  <= w_dmem_read_nxt;
      r_dmem_write <= w_dmem_write_nxt;
      r_regwrite   <= w_regwrite_nxt;
      r_memtoreg   <= w_memtoreg_nxt;
      r_link       <= w_link_nxt;
    end
  end

  assign imem_addr  = r_pc;
  assign imem_req   = r_imem_req;
  assign RS1        = w_rs1;
  assign RS2        = w_rs2;
  assign RD         = w_rd;
  assign IMM        = w_imm;
  assign ALUControl = WIDTH_ALUF'(w_alu_op);
  assign ALUSrc     = w_alu_src;
  assign MemtoReg   = r_memtoreg;
  assign RegWrite   = r_regwrite;
  assign link       = r_link;
  assign pclink     = w_pc_plus4;
  assign dmem_read  = r_dmem_read;
  assign dmem_write = r_dmem_write;
  assign illegal    = r_illegal;
  assign state_dbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_controller                                                   |
// | Instruction-level reference model bench for multicycle_controller.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

  localparam int NBITS = 8;
  localparam int NREGS = 32;
  localparam int WIDTH_ALUF = 4;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4, K_ADDI = 5;
  localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9, K_BLT = 10, K_JAL = 11, K_JALR = 12;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NBITS-1:0] imem_addr;
  logic             imem_req;
  logic             imem_ack = 1'b0;
  logic [31:0]      imem_rdata = 32'h0;
  logic [4:0]       RS1, RS2, RD;
  logic [NBITS-1:0] IMM;
  logic [3:0]       ALUControl;
  logic             ALUSrc, MemtoReg, RegWrite, link;
  logic [NBITS-1:0] pclink;
  logic [NBITS-1:0] PCReg = '0;
  logic             Zero = 1'b0, Neg = 1'b0, Carry = 1'b0;
  logic             dmem_read, dmem_write;
  logic             dmem_ack = 1'b0;
  logic             illegal;
  logic [2:0]       state_dbg;

  multicycle_controller #(
    .NBITS(NBITS), .NREGS(NREGS), .WIDTH_ALUF(WIDTH_ALUF)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .link(link), .pclink(pclink), .PCReg(PCReg),
    .Zero(Zero), .Neg(Neg), .Carry(Carry),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_ack(dmem_ack),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int m_pc  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int k, input int rd, input int rs1, input int rs2, input int imm);
    logic [31:0] v;
    logic [4:0]  d, a, b;
    v = imm;
    d = 5'(rd);
    a = 5'(rs1);
    b = 5'(rs2);
    case (k)
      K_ADD:  return {7'h00, b, a, 3'b000, d, 7'b0110011};
      K_SUB:  return {7'h20, b, a, 3'b000, d, 7'b0110011};
      K_AND:  return {7'h00, b, a, 3'b111, d, 7'b0110011};
      K_OR:   return {7'h00, b, a, 3'b110, d, 7'b0110011};
      K_XOR:  return {7'h00, b, a, 3'b100, d, 7'b0110011};
      K_ADDI: return {v[11:0], a, 3'b000, d, 7'b0010011};
      K_LW:   return {v[11:0], a, 3'b010, d, 7'b0000011};
      K_SW:   return {v[11:5], b, a, 3'b010, v[4:0], 7'b0100011};
      K_BEQ:  return {v[12], v[10:5], b, a, 3'b000, v[4:1], v[11], 7'b1100011};
      K_BNE:  return {v[12], v[10:5], b, a, 3'b001, v[4:1], v[11], 7'b1100011};
      K_BLT:  return {v[12], v[10:5], b, a, 3'b100, v[4:1], v[11], 7'b1100011};
      K_JAL:  return {v[20], v[10:1], v[11], v[19:12], d, 7'b1101111};
      K_JALR: return {v[11:0], a, 3'b000, d, 7'b1100111};
      default: return 32'h0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick(); tick();
    chk("rst_state", state_dbg, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_dread", dmem_read, 0);
    chk("rst_dwrite", dmem_write, 0);
    chk("rst_link", link, 0);
    chk("rst_m2r", MemtoReg, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_aluctl", ALUControl, 0);
    chk("rst_fields", {RS1, RS2, RD, IMM}, 0);
    reset = 1'b0;
    m_pc = 0;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (!imem_req && n < 4) begin tick(); n++; end
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
  endtask

  // Runs one instruction and checks it against the instruction-level expectations.
  task automatic run_instr(input int k, input int rd, input int rs1, input int rs2, input int imm,
                           input int ack_dly, input int dm_dly, input logic z, input logic n,
                           input logic [7:0] pcr);
    int cyc, hold_bad, rw_cnt, dr, dw, got_rd, exp_pc, exp_cpi;
    logic got_m2r, got_link;
    logic [7:0] got_pcl;
    bit is_r, writes, taken;
    is_r   = (k <= K_XOR);
    writes = is_r || k == K_ADDI || k == K_LW || k == K_JAL || k == K_JALR;
    taken  = (k == K_BEQ && z) || (k == K_BNE && !z) || (k == K_BLT && n);
    case (k)
      K_BEQ, K_BNE, K_BLT: begin exp_pc = taken ? m_pc + imm : m_pc + 4; exp_cpi = 3; end
      K_JAL:  begin exp_pc = m_pc + imm; exp_cpi = 4; end
      K_JALR: begin exp_pc = (int'(pcr) + imm) & ~1; exp_cpi = 4; end
      K_LW:   begin exp_pc = m_pc + 4; exp_cpi = 4 + dm_dly; end
      K_SW:   begin exp_pc = m_pc + 4; exp_cpi = 3 + dm_dly; end
      default: begin exp_pc = m_pc + 4; exp_cpi = 4; end
    endcase
    exp_pc = exp_pc & 255;

    Zero = z; Neg = n; PCReg = pcr; Carry = 1'($urandom);
    wait_fetch();
    hold_bad = 0;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      if (imem_req !== 1'b1 || imem_addr !== 8'(m_pc) || RegWrite !== 1'b0 || state_dbg !== 3'd0)
        hold_bad++;
    end
    if (ack_dly > 0) chk("fetch_hold", hold_bad, 0);
    imem_ack = 1'b1; imem_rdata = enc(k, rd, rs1, rs2, imm);
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    cyc = 1;

    chk("dec_state", state_dbg, 1);
    if (k != K_JAL) chk("dec_rs1", RS1, rs1);
    if (is_r || k == K_SW || k == K_BEQ || k == K_BNE || k == K_BLT) chk("dec_rs2", RS2, rs2);
    if (writes) chk("dec_rd", RD, rd);
    chk("dec_imm", IMM, is_r ? 0 : (imm & 255));
    if (k <= K_BLT) begin
      chk("dec_aluctl", ALUControl, (k == K_SUB || k >= K_BEQ) ? 1 :
                                    (k == K_AND) ? 2 : (k == K_OR) ? 3 : (k == K_XOR) ? 4 : 0);
      chk("dec_alusrc", ALUSrc, (k == K_ADDI || k == K_LW || k == K_SW) ? 1 : 0);
    end

    rw_cnt = 0; dr = 0; dw = 0; got_rd = 0;
    got_m2r = 1'b0; got_link = 1'b0; got_pcl = '0;
    while (!imem_req && cyc < 40) begin
      if (RegWrite) begin
        rw_cnt++; got_rd = int'(RD); got_m2r = MemtoReg; got_link = link; got_pcl = pclink;
      end
      if (dmem_read) dr++;
      if (dmem_write) dw++;
      dmem_ack = (dmem_read || dmem_write) && (dr + dw == dm_dly);
      tick();
      cyc++;
    end
    dmem_ack = 1'b0;

    chk("cpi", cyc, exp_cpi);
    chk("next_pc", imem_addr, exp_pc);
    chk("regwrite_cycles", rw_cnt, writes ? 1 : 0);
    if (writes) begin
      chk("wb_rd", got_rd, rd);
      chk("wb_memtoreg", got_m2r, k == K_LW);
      chk("wb_link", got_link, (k == K_JAL || k == K_JALR));
      if (k == K_JAL || k == K_JALR) chk("wb_pclink", got_pcl, (m_pc + 4) & 255);
    end
    chk("dmem_read_cycles", dr, (k == K_LW) ? dm_dly : 0);
    chk("dmem_write_cycles", dw, (k == K_SW) ? dm_dly : 0);
    chk("illegal_clear", illegal, 0);
    m_pc = exp_pc;
  endtask

  task automatic illegal_test(input logic [31:0] word);
    int quiet_bad;
    wait_fetch();
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req || RegWrite || dmem_read || dmem_write || link) quiet_bad++;
    end
    chk("halt_state", state_dbg, 5);
    chk("halt_illegal", illegal, 1);
    chk("halt_quiet", quiet_bad, 0);
    chk("halt_pc", imem_addr, m_pc);
  endtask

  function automatic int rand_imm(input int k);
    case (k)
      K_ADDI, K_LW, K_SW, K_JALR: return int'($urandom_range(0, 4095)) - 2048;
      K_BEQ, K_BNE, K_BLT:        return (int'($urandom_range(0, 4095)) - 2048) * 2;
      K_JAL:                      return (int'($urandom_range(0, 65535)) - 32768) * 2;
      default:                    return 0;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k, cyc;
    do_reset();

    run_instr(K_ADDI, 1, 0, 0, 5, 5, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_ADD, 3, 1, 2, 0, 2, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_SUB, 4, 3, 1, 0, 0, 1, 1'b1, 1'b1, 8'h00);
    run_instr(K_BEQ, 0, 0, 0, -8, 0, 1, 1'b1, 1'b0, 8'h00);
    run_instr(K_AND, 5, 4, 3, 0, 1, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_XOR, 6, 5, 4, 0, 0, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_BEQ, 0, 0, 0, -8, 0, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_LW, 2, 1, 0, 4, 0, 3, 1'b0, 1'b0, 8'h00);
    run_instr(K_SW, 0, 1, 2, 8, 0, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_JAL, 1, 0, 0, -16, 0, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_JAL, 1, 0, 0, 16, 0, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_JALR, 0, 1, 0, 0, 0, 1, 1'b0, 1'b0, 8'd13);
    run_instr(K_BNE, 0, 1, 2, 20, 0, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_BLT, 0, 1, 2, -12, 0, 1, 1'b0, 1'b1, 8'h00);
    run_instr(K_BLT, 0, 1, 2, -12, 0, 1, 1'b1, 1'b0, 8'h00);
    run_instr(K_OR, 0, 7, 8, 0, 0, 1, 1'b0, 1'b0, 8'h00);
    run_instr(K_ADDI, 0, 0, 0, -1, 0, 1, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 12));
      run_instr(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), rand_imm(k), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 4)), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    illegal_test($urandom & 32'hFFFF_FF80);
    do_reset();
    run_instr(K_ADDI, 9, 0, 0, 100, 0, 1, 1'b0, 1'b0, 8'h00);
    illegal_test({7'h00, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011});

    // reset while a load is outstanding in MEM
    do_reset();
    wait_fetch();
    imem_ack = 1'b1; imem_rdata = enc(K_LW, 2, 1, 0, 4);
    tick();
    imem_ack = 1'b0;
    cyc = 0;
    while (!dmem_read && cyc < 10) begin tick(); cyc++; end
    chk("mm_dread_high", dmem_read, 1);
    reset = 1'b1;
    tick();
    chk("mm_state", state_dbg, 0);
    chk("mm_pc", imem_addr, 0);
    chk("mm_dread_drop", dmem_read, 0);
    chk("mm_no_wb", RegWrite, 0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    reset = 1'b0;
    m_pc = 0;
    run_instr(K_ADDI, 1, 0, 0, 5, 0, 1, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
